alu_system: RTL and testbench

Top-level datapath: a general-purpose register file (RF), an address register file (ARF), a 16-bit instruction register (IR), an 8-bit ALU with a registered flag set, a 256x8 memory and three source multiplexers. All control comes from input ports, one control word per clock, and the block has no data output ports. The required internal nets below are the observation points for the bench. It is built from a generic n-bit register primitive with 8-bit and 16-bit variants.

---
 rtl/alu_system_if.sv | 35 +++
 rtl/alu_system.sv | 199 +++++++++++++++++++
 tb/tb_alu_system.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_system_if.sv
// Control word for alu_system: one full set of datapath controls per clock.
// The driver of the control word uses master; the datapath uses slave.
interface alu_system_if;
    logic [1:0] RF_OutASel;
    logic [1:0] RF_OutBSel;
    logic [1:0] RF_FunSel;
    logic [3:0] RF_RegSel;
    logic [3:0] ALU_FunSel;
    logic [1:0] ARF_OutCSel;
    logic [1:0] ARF_OutDSel;
    logic [1:0] ARF_FunSel;
    logic [2:0] ARF_RegSel;
    logic       IR_LH;
    logic       IR_Enable;
    logic [1:0] IR_Funsel;
    logic       Mem_WR;
    logic       Mem_CS;
    logic [1:0] MuxASel;
    logic [1:0] MuxBSel;
    logic       MuxCSel;

    modport master (
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel
    );

    modport slave (
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel
    );
endinterface

// File: rtl/alu_system.sv
// Register-file / ALU / memory datapath driven entirely by a per-cycle control
// word; built from one generic n-bit register primitive.
module alu_system_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  logic [1:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q
);
    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // which is what makes ALU-to-register feedback paths well defined.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Q <= '0;
        end else if (E) begin
            case (FunSel)
                2'b00:   Q <= Q - WIDTH'(1);
                2'b01:   Q <= Q + WIDTH'(1);
                2'b10:   Q <= I;
                default: Q <= '0;
            endcase
        end
    end
endmodule

module alu_system (
    input  logic         Clock,
    input  logic         Reset,
    alu_system_if.slave  ctrl
);
    logic [7:0]  AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut;
    logic [7:0]  MuxAOut, MuxBOut, MuxCOut;
    logic [3:0]  ALUOutFlag;
    logic [15:0] IROut;

    logic [7:0]  rf_q [4];
    logic [7:0]  pc_q, ar_q, sp_q;
    logic [15:0] ir_in;
    logic [3:0]  flag_q, flag_d;
    logic [8:0]  alu_sum;
    logic        alu_c, alu_o, c_upd, o_upd, c_in;
    logic [7:0]  mem_q [256];

    function automatic logic [7:0] arf_read(input logic [1:0] sel,
                                            input logic [7:0] pc, ar, sp);
        case (sel)
            2'b10:   return ar;
            2'b11:   return sp;
            default: return pc;
        endcase
    endfunction

    function automatic logic [7:0] src_mux(input logic [1:0] sel,
                                           input logic [7:0] alu, mem, ir_lo, arf_c);
        case (sel)
            2'b00:   return alu;
            2'b01:   return mem;
            2'b10:   return ir_lo;
            default: return arf_c;
        endcase
    endfunction

    // R1..R4 live in rf_q[0..3]; RegSel bit 3 enables R1, active-low.
    for (genvar i = 0; i < 4; i++) begin : g_rf
        alu_system_reg #(.WIDTH(8)) u_rf (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (~ctrl.RF_RegSel[3-i]),
            .FunSel (ctrl.RF_FunSel),
            .I      (MuxAOut),
            .Q      (rf_q[i])
        );
    end

    alu_system_reg #(.WIDTH(8)) u_pc (
        .Clock(Clock), .Reset(Reset), .E(~ctrl.ARF_RegSel[2]),
        .FunSel(ctrl.ARF_FunSel), .I(MuxBOut), .Q(pc_q)
    );
    alu_system_reg #(.WIDTH(8)) u_ar (
        .Clock(Clock), .Reset(Reset), .E(~ctrl.ARF_RegSel[1]),
        .FunSel(ctrl.ARF_FunSel), .I(MuxBOut), .Q(ar_q)
    );
    alu_system_reg #(.WIDTH(8)) u_sp (
        .Clock(Clock), .Reset(Reset), .E(~ctrl.ARF_RegSel[0]),
        .FunSel(ctrl.ARF_FunSel), .I(MuxBOut), .Q(sp_q)
    );

    // A half-load is a full 16-bit load with the untouched half fed back.
    assign ir_in = ctrl.IR_LH ? {MemoryOut, IROut[7:0]} : {IROut[15:8], MemoryOut};

    alu_system_reg #(.WIDTH(16)) u_ir (
        .Clock(Clock), .Reset(Reset), .E(ctrl.IR_Enable),
        .FunSel(ctrl.IR_Funsel), .I(ir_in), .Q(IROut)
    );

    assign AOut     = rf_q[ctrl.RF_OutASel];
    assign BOut     = rf_q[ctrl.RF_OutBSel];
    assign ARF_COut = arf_read(ctrl.ARF_OutCSel, pc_q, ar_q, sp_q);
    assign Address  = arf_read(ctrl.ARF_OutDSel, pc_q, ar_q, sp_q);
    assign MuxAOut  = src_mux(ctrl.MuxASel, ALUOut, MemoryOut, IROut[7:0], ARF_COut);
    assign MuxBOut  = src_mux(ctrl.MuxBSel, ALUOut, MemoryOut, IROut[7:0], ARF_COut);
    assign MuxCOut  = ctrl.MuxCSel ? ARF_COut : AOut;
    assign c_in     = ALUOutFlag[2];

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        alu_sum = '0;
        ALUOut  = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        c_upd   = 1'b0;
        o_upd   = 1'b0;
        case (ctrl.ALU_FunSel)
            4'b0000: ALUOut = MuxCOut;
            4'b0001: ALUOut = BOut;
            4'b0010: ALUOut = ~MuxCOut;
            4'b0011: ALUOut = ~BOut;
            4'b0100, 4'b0101: begin
                alu_sum = {1'b0, MuxCOut} + {1'b0, BOut}
                        + {8'd0, (ctrl.ALU_FunSel[0] & c_in)};
                ALUOut  = alu_sum[7:0];
                alu_c   = alu_sum[8];
                alu_o   = (MuxCOut[7] == BOut[7]) && (ALUOut[7] != MuxCOut[7]);
                c_upd   = 1'b1;
                o_upd   = 1'b1;
            end
            4'b0110: begin
                alu_sum = {1'b0, MuxCOut} + {1'b0, ~BOut} + 9'd1;
                ALUOut  = alu_sum[7:0];
                alu_c   = alu_sum[8];
                alu_o   = (MuxCOut[7] != BOut[7]) && (ALUOut[7] != MuxCOut[7]);
                c_upd   = 1'b1;
                o_upd   = 1'b1;
            end
            4'b0111: ALUOut = MuxCOut & BOut;
            4'b1000: ALUOut = MuxCOut | BOut;
            4'b1001: ALUOut = MuxCOut ^ BOut;
            4'b1010: begin
                ALUOut = {MuxCOut[6:0], 1'b0};
                alu_c  = MuxCOut[7];
                c_upd  = 1'b1;
            end
            4'b1011: begin
                ALUOut = {1'b0, MuxCOut[7:1]};
                alu_c  = MuxCOut[0];
                c_upd  = 1'b1;
            end
            4'b1100: begin
                // Sign bit stays put; O reports that a plain shift would have flipped it.
                ALUOut = {MuxCOut[7], MuxCOut[5:0], 1'b0};
                alu_c  = MuxCOut[6];
                alu_o  = MuxCOut[7] ^ MuxCOut[6];
                c_upd  = 1'b1;
                o_upd  = 1'b1;
            end
            4'b1101: begin
                ALUOut = {MuxCOut[7], MuxCOut[7:1]};
                alu_c  = MuxCOut[0];
                c_upd  = 1'b1;
            end
            4'b1110: begin
                ALUOut = {MuxCOut[6:0], c_in};
                alu_c  = MuxCOut[7];
                c_upd  = 1'b1;
            end
            default: begin
                ALUOut = {c_in, MuxCOut[7:1]};
                alu_c  = MuxCOut[0];
                c_upd  = 1'b1;
            end
        endcase
    end

    always_comb begin
        flag_d    = ALUOutFlag;
        flag_d[3] = (ALUOut == 8'h00);
        flag_d[1] = ALUOut[7];
        if (c_upd) flag_d[2] = alu_c;
        if (o_upd) flag_d[0] = alu_o;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) flag_q <= '0;
        else        flag_q <= flag_d;
    end

    assign ALUOutFlag = flag_q;

    // NOTE: the memory array is intentionally left out of reset; its contents
    // survive Reset and power up from the target's zero initialisation.
    always_ff @(posedge Clock) begin
        if (!ctrl.Mem_CS && ctrl.Mem_WR) mem_q[Address] <= ALUOut;
    end

    assign MemoryOut = (!ctrl.Mem_CS && !ctrl.Mem_WR) ? mem_q[Address] : 8'h00;
endmodule

// File: tb/tb_alu_system.sv
// Directed bench for alu_system: drives control words and checks the
// internal observation nets against hand-computed values.
module tb_alu_system;
    logic Clock = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_system_if ctrl ();

    alu_system dut (
        .Clock (Clock),
        .Reset (Reset),
        .ctrl  (ctrl)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        ctrl.RF_OutASel  = 2'b00;
        ctrl.RF_OutBSel  = 2'b00;
        ctrl.RF_FunSel   = 2'b00;
        ctrl.RF_RegSel   = 4'b1111;
        ctrl.ALU_FunSel  = 4'b0000;
        ctrl.ARF_OutCSel = 2'b00;
        ctrl.ARF_OutDSel = 2'b00;
        ctrl.ARF_FunSel  = 2'b00;
        ctrl.ARF_RegSel  = 3'b111;
        ctrl.IR_LH       = 1'b0;
        ctrl.IR_Enable   = 1'b0;
        ctrl.IR_Funsel   = 2'b00;
        ctrl.Mem_WR      = 1'b0;
        ctrl.Mem_CS      = 1'b1;
        ctrl.MuxASel     = 2'b00;
        ctrl.MuxBSel     = 2'b00;
        ctrl.MuxCSel     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every enable asserted and increment selected: reset must win.
        idle();
        Reset = 1'b0;
        ctrl.RF_RegSel  = 4'b0000; ctrl.RF_FunSel  = 2'b01;
        ctrl.ARF_RegSel = 3'b000;  ctrl.ARF_FunSel = 2'b01;
        ctrl.IR_Enable  = 1'b1;    ctrl.IR_Funsel  = 2'b01;
        tick();
        Reset = 1'b1;
        idle();
        #1;
        for (int s = 0; s < 4; s++) begin
            ctrl.RF_OutASel = 2'(s);
            #1 check($sformatf("rst_R%0d", s + 1), 16'(dut.AOut), 16'h0000);
        end
        ctrl.ARF_OutCSel = 2'b00; #1 check("rst_PC", 16'(dut.ARF_COut), 16'h0000);
        ctrl.ARF_OutCSel = 2'b10; #1 check("rst_AR", 16'(dut.ARF_COut), 16'h0000);
        ctrl.ARF_OutCSel = 2'b11; #1 check("rst_SP", 16'(dut.ARF_COut), 16'h0000);
        check("rst_flags", 16'(dut.ALUOutFlag), 16'h0000);
        check("rst_IR", dut.IROut, 16'h0000);

        // Build R1=E4 and R2=44 by counting.
        idle(); ctrl.RF_FunSel = 2'b01; ctrl.RF_RegSel = 4'b0111;
        repeat (228) tick();
        ctrl.RF_RegSel = 4'b1011;
        repeat (68) tick();
        idle(); ctrl.RF_OutBSel = 2'b01;
        #1 check("R1_count", 16'(dut.AOut), 16'h00E4);
        check("R2_count", 16'(dut.BOut), 16'h0044);

        // Mem[0]=E4, Mem[1]=44.
        idle(); ctrl.Mem_CS = 1'b0; ctrl.Mem_WR = 1'b1;
        #1 check("memout_during_wr", 16'(dut.MemoryOut), 16'h0000);
        tick();
        idle(); ctrl.ARF_FunSel = 2'b01; ctrl.ARF_RegSel = 3'b011; tick();
        idle(); ctrl.ALU_FunSel = 4'b0001; ctrl.RF_OutBSel = 2'b01;
        ctrl.Mem_CS = 1'b0; ctrl.Mem_WR = 1'b1; tick();
        idle(); ctrl.ARF_FunSel = 2'b11; ctrl.ARF_RegSel = 3'b011; tick();
        idle(); ctrl.Mem_CS = 1'b0;
        #1 check("addr_pc0", 16'(dut.Address), 16'h0000);
        check("mem0_read", 16'(dut.MemoryOut), 16'h00E4);

        // IR half loads, increment, clear.
        ctrl.IR_Enable = 1'b1; ctrl.IR_Funsel = 2'b10; ctrl.IR_LH = 1'b0; tick();
        check("ir_lo_load", dut.IROut, 16'h00E4);
        idle(); ctrl.ARF_FunSel = 2'b01; ctrl.ARF_RegSel = 3'b011; tick();
        idle(); ctrl.Mem_CS = 1'b0;
        #1 check("mem1_read", 16'(dut.MemoryOut), 16'h0044);
        ctrl.IR_Enable = 1'b1; ctrl.IR_Funsel = 2'b10; ctrl.IR_LH = 1'b1; tick();
        check("ir_hi_load", dut.IROut, 16'h44E4);
        ctrl.IR_Funsel = 2'b01; tick();
        check("ir_inc", dut.IROut, 16'h44E5);
        ctrl.IR_Funsel = 2'b11; tick();
        check("ir_clr", dut.IROut, 16'h0000);
        idle(); ctrl.ARF_FunSel = 2'b11; ctrl.ARF_RegSel = 3'b011; tick();
        idle(); ctrl.Mem_CS = 1'b0; ctrl.IR_Enable = 1'b1; ctrl.IR_Funsel = 2'b10; tick();
        check("ir_reload", dut.IROut, 16'h00E4);

        // R1 cleared, then loaded from IR low through MuxA.
        idle(); ctrl.RF_FunSel = 2'b11; ctrl.RF_RegSel = 4'b0111; tick();
        check("R1_clr", 16'(dut.AOut), 16'h0000);
        ctrl.RF_FunSel = 2'b10; ctrl.MuxASel = 2'b10; tick();
        check("R1_from_ir", 16'(dut.AOut), 16'h00E4);

        // Add E4+E4.
        idle(); ctrl.ALU_FunSel = 4'b0100;
        #1 check("add_out", 16'(dut.ALUOut), 16'h00C8);
        tick();
        check("add_flags", 16'(dut.ALUOutFlag), 16'h0006);

        // LSR E4 written straight into R3.
        idle(); ctrl.ALU_FunSel = 4'b1011;
        ctrl.RF_FunSel = 2'b10; ctrl.RF_RegSel = 4'b1101; ctrl.MuxASel = 2'b00;
        #1 check("lsr_e4_out", 16'(dut.ALUOut), 16'h0072);
        tick();
        idle(); ctrl.RF_OutBSel = 2'b10;
        #1 check("R3_from_alu", 16'(dut.BOut), 16'h0072);
        check("lsr_e4_flags", 16'(dut.ALUOutFlag), 16'h0000);

        // LSL E4 sets C; CSR 72 rotates it in.
        idle(); ctrl.ALU_FunSel = 4'b1010;
        #1 check("lsl_out", 16'(dut.ALUOut), 16'h00C8);
        tick();
        check("lsl_flags", 16'(dut.ALUOutFlag), 16'h0006);
        idle(); ctrl.ALU_FunSel = 4'b1111; ctrl.RF_OutASel = 2'b10;
        #1 check("csr_out", 16'(dut.ALUOut), 16'h00B9);
        tick();
        check("csr_flags", 16'(dut.ALUOutFlag), 16'h0002);
        ctrl.ALU_FunSel = 4'b1011;
        #1 check("lsr_72_out", 16'(dut.ALUOut), 16'h0039);
        tick();
        check("lsr_72_flags", 16'(dut.ALUOutFlag), 16'h0000);

        // Subtract to zero, add with carry, signed overflow, O held by AND.
        idle(); ctrl.ALU_FunSel = 4'b0110;
        #1 check("sub_out", 16'(dut.ALUOut), 16'h0000);
        tick();
        check("sub_flags", 16'(dut.ALUOutFlag), 16'h000C);
        idle(); ctrl.ALU_FunSel = 4'b0101; ctrl.RF_OutBSel = 2'b10;
        #1 check("adc_out", 16'(dut.ALUOut), 16'h0057);
        tick();
        check("adc_flags", 16'(dut.ALUOutFlag), 16'h0004);
        idle(); ctrl.ALU_FunSel = 4'b0100; ctrl.RF_OutASel = 2'b10; ctrl.RF_OutBSel = 2'b10;
        #1 check("ovf_out", 16'(dut.ALUOut), 16'h00E4);
        tick();
        check("ovf_flags", 16'(dut.ALUOutFlag), 16'h0003);
        idle(); ctrl.ALU_FunSel = 4'b0111; ctrl.RF_OutBSel = 2'b10;
        #1 check("and_out", 16'(dut.ALUOut), 16'h0060);
        tick();
        check("and_flags", 16'(dut.ALUOutFlag), 16'h0001);

        // Register primitive wrap-around and hold on R2.
        idle(); ctrl.RF_OutBSel = 2'b01; ctrl.RF_RegSel = 4'b1011;
        ctrl.RF_FunSel = 2'b11; tick();
        check("R2_clr", 16'(dut.BOut), 16'h0000);
        ctrl.RF_FunSel = 2'b00; tick();
        check("R2_dec_wrap", 16'(dut.BOut), 16'h00FF);
        ctrl.RF_FunSel = 2'b01; tick();
        check("R2_inc_wrap", 16'(dut.BOut), 16'h0000);
        ctrl.RF_FunSel = 2'b10; ctrl.ALU_FunSel = 4'b0010; ctrl.RF_OutASel = 2'b11; tick();
        check("R2_load_ff", 16'(dut.BOut), 16'h00FF);
        ctrl.RF_FunSel = 2'b01; tick();
        check("R2_inc_ff", 16'(dut.BOut), 16'h0000);
        ctrl.RF_FunSel = 2'b00; tick();
        ctrl.RF_FunSel = 2'b11; ctrl.RF_RegSel = 4'b1111; tick();
        check("R2_hold", 16'(dut.BOut), 16'h00FF);
        ctrl.RF_OutASel = 2'b00;
        #1 check("R1_untouched", 16'(dut.AOut), 16'h00E4);

        // AR=10, R4=5A, then write Mem[10] while IR loads from MemoryOut.
        idle(); ctrl.ARF_FunSel = 2'b11; ctrl.ARF_RegSel = 3'b101; tick();
        ctrl.ARF_FunSel = 2'b01;
        repeat (16) tick();
        idle(); ctrl.RF_FunSel = 2'b01; ctrl.RF_RegSel = 4'b1110;
        repeat (90) tick();
        idle(); ctrl.ARF_OutCSel = 2'b10; ctrl.RF_OutASel = 2'b11;
        #1 check("AR_count", 16'(dut.ARF_COut), 16'h0010);
        check("R4_count", 16'(dut.AOut), 16'h005A);
        ctrl.ARF_OutDSel = 2'b10; ctrl.Mem_CS = 1'b0; ctrl.Mem_WR = 1'b1;
        ctrl.IR_Enable = 1'b1; ctrl.IR_Funsel = 2'b10; ctrl.IR_LH = 1'b0;
        #1 check("wr_memout_zero", 16'(dut.MemoryOut), 16'h0000);
        tick();
        check("ir_during_wr", dut.IROut, 16'h0000);
        ctrl.IR_Enable = 1'b0; ctrl.Mem_WR = 1'b0;
        #1 check("mem10_read", 16'(dut.MemoryOut), 16'h005A);
        ctrl.Mem_CS = 1'b1;
        #1 check("cs_high_memout", 16'(dut.MemoryOut), 16'h0000);

        // MuxC from ARF, and SP loaded from ARF_COut via MuxB.
        idle(); ctrl.MuxCSel = 1'b1; ctrl.ARF_OutCSel = 2'b10;
        #1 check("muxc_arf", 16'(dut.ALUOut), 16'h0010);
        ctrl.MuxBSel = 2'b11; ctrl.ARF_FunSel = 2'b10; ctrl.ARF_RegSel = 3'b110; tick();
        ctrl.ARF_OutCSel = 2'b11;
        #1 check("SP_from_arf", 16'(dut.ARF_COut), 16'h0010);

        // Reset again: registers clear, memory keeps its contents.
        Reset = 1'b0; tick();
        Reset = 1'b1; idle(); ctrl.ARF_OutCSel = 2'b10; ctrl.Mem_CS = 1'b0;
        #1 check("rst2_AR", 16'(dut.ARF_COut), 16'h0000);
        check("rst2_R1", 16'(dut.AOut), 16'h0000);
        check("rst2_flags", 16'(dut.ALUOutFlag), 16'h0000);
        check("rst2_mem0", 16'(dut.MemoryOut), 16'h00E4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
